// File: rtl/spi_flash_read_ctrl.sv
// SPI flash word reader: one READ (0x03) frame per request, 4 bytes returned little-endian.
// Latency: resp_valid rises 128*CLK_DIV+1 cycles after the accept cycle.
// Backpressure: one request in flight; req_ready low until the response handshake and the CS gap finish.
module spi_flash_read_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int ADDR_BITS = 24,
  parameter int CS_GAP    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic                 sck,
  output logic                 cs_0,
  output logic                 dq_0,
  input  logic                 dq_1
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP, GAP} state_t;

  state_t            state_q, state_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic [63:0]       sreg_q, sreg_d;
  logic [31:0]       rx_q, rx_d;
  logic [6:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic [23:0]       addr24;

  // The flash always sees a 24-bit address: narrow inputs are zero-extended, wide ones truncated.
  generate
    if (ADDR_BITS >= 24) begin : g_addr_trunc
      assign addr24 = req_addr[23:0];
    end else begin : g_addr_ext
      assign addr24 = {{(24-ADDR_BITS){1'b0}}, req_addr};
    end
  endgenerate

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign cs_0       = cs_q;
  assign dq_0       = sreg_q[63];

  // State register; reset drops cs_0 high and sck low immediately, aborting any frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      sreg_q      <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      sreg_q      <= sreg_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state: frame sequencing, sck generation, MOSI shift and MISO capture.
  always_comb begin
    state_d     = state_q;
    sck_d       = sck_q;
    cs_d        = cs_q;
    sreg_d      = sreg_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    gap_d       = gap_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = SHIFT;
          cs_d      = 1'b0;
          sck_d     = 1'b0;
          sreg_d    = {8'h03, addr24, 32'h0};
          rx_d      = '0;
          bit_cnt_d = '0;
          div_d     = '0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            // Rising edge: the flash has had a full half-period to present the read bit.
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q[5]) begin
              rx_d = {rx_q[30:0], dq_1};
            end
          end else if (bit_cnt_q == 7'd64) begin
            // The falling point after the last rise closes the frame instead of shifting.
            sck_d       = 1'b0;
            cs_d        = 1'b1;
            state_d     = RESP;
            resp_data_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          end else begin
            sck_d  = 1'b0;
            sreg_d = {sreg_q[62:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
Host-side sequencer for the simulated SPI flash. It turns a word-read request on a valid/ready interface into a single-lane SPI READ (0x03) transaction on sck/cs_0/dq_0/dq_1. It then assembles 4 returned bytes into one 32-bit response. It sits between the SoC boot/fetch path and the flash pins, and serialises all flash accesses.

Parameters:
CLK_DIV, 2, sck half-period in clock cycles (>=1); sck period = 2*CLK_DIV
ADDR_BITS, 24, width of req_addr; zero-extended to the 24-bit SPI address
CS_GAP, 2, minimum clock cycles cs_0 stays high between transactions (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  read request valid
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_BITS  byte address of first byte
resp_valid  out  1  response data valid
resp_ready  in  1  consumer accepts response
resp_data  out  32  bytes A..A+3, little-endian (byte A in [7:0])
sck  out  1  SPI clock, mode 0 (idle low)
cs_0  out  1  chip select, active low
dq_0  out  1  MOSI, always driven by this block
dq_1  in  1  MISO from flash

Behaviour:
- Reset (synchronous, active-high) sets: state IDLE, sck=0, cs_0=1, dq_0=0, req_ready=1, resp_valid=0, resp_data=0.
- Reset asserted mid-transaction aborts it: the next edge gives cs_0=1 and sck=0, and no response is produced.
- States: IDLE, SHIFT, RESP, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch {0x03, addr[23:0], 32'b0} into a 64-bit shift register and clear the bit counter.
  - Next cycle: cs_0=0, sck=0, dq_0 = bit 63.
  - Go to SHIFT.
- SHIFT:
  - A half-period counter counts CLK_DIV cycles, then toggles sck.
  - On each rising toggle: sample dq_1 into the receive shift register, but only for bits 32..63 of the frame; increment the bit counter.
  - On each falling toggle: shift dq_0 to the next frame bit (MSB first).
  - Frame order: 8 cmd bits, 24 address bits, then 32 read bits. dq_0=0 during the read bits.
  - After the 64th rising toggle, the falling-toggle point instead drives sck=0 and cs_0=1, and moves to RESP.
- Frame timing:
  - Frame = 64 sck periods = 128*CLK_DIV cycles.
  - resp_valid first asserts 128*CLK_DIV+1 cycles after the accept cycle.
- Byte assembly:
  - Each byte is received MSB first.
  - The k-th received byte (k=0..3) goes to resp_data[8k+7:8k].
- RESP:
  - resp_valid=1; resp_data is stable until handshake; req_ready=0.
  - On resp_ready: resp_valid=0 and go to GAP.
  - resp_ready asserted in the same cycle resp_valid first rises completes the handshake that cycle.
- GAP:
  - cs_0 held high for CS_GAP cycles, then go to IDLE.
  - Minimum accept-to-accept spacing = 128*CLK_DIV + 1 + 1 + CS_GAP cycles.
- req_ready is 0 in every state except IDLE. No request queuing; req_addr is sampled only at accept.
- ADDR_BITS<24: upper address bits are 0. ADDR_BITS>24: bits above 23 are ignored (flash wraps).
- Address wrap inside a word (A=0xFFFFFE) is the flash's responsibility; the controller just clocks 32 bits.
- sck never glitches: exactly 64 rising edges per frame, and sck is low whenever cs_0 toggles.

Test Plan:
1. Baseline read: CLK_DIV=2, flash bytes 0x10..0x13 = 11 22 33 44, request addr 0x000010, resp_ready=1.
   -> dq_0 sampled on sck rises = 0x03 then 0x000010; resp_data=0x44332211; resp_valid 257 cycles after accept; exactly 64 sck rises.
2. Response backpressure: hold resp_ready=0 for 10 cycles after resp_valid.
   -> resp_data stable; resp_valid held; req_ready=0 and cs_0=1 throughout; GAP starts after the handshake.
3. Back-to-back: req_valid held high with addrs 0x0, then 0x4.
   -> second accept only after GAP; cs_0 high for >=CS_GAP=2 cycles between frames; responses in order.
4. Reset mid-frame: assert reset for 1 cycle during the address phase (after 20 sck rises).
   -> next cycle cs_0=1, sck=0, resp_valid=0, req_ready=1; no response; a later request completes correctly.
5. Fast divider: CLK_DIV=1, read addr 0x0 with bytes DE AD BE EF.
   -> resp_data=0xEFBEADDE; latency 129 cycles; sck period 2 cycles.
